huc_mem_arb: RTL



---
 rtl/huc_mem_arb.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/huc_mem_arb.sv
// huc_mem_arb: shares the single cart SRAM port between the HuCard CPU bus
// (via the mapper) and the host loader. Each access is a fixed strobe
// window of MEM_CYC clocks. The CPU always wins; the host gets idle slots.
//
// Optional build macro: HUC_MEM_ARB_HOST_AUTOINC_EN
//   Defined: host accesses use an internal pointer that is loaded from
//   host_addr when host_req rises and increments after every host access,
//   so the host can burst by holding host_req across acks.
//   Undefined: host_addr is used directly for every access.
//
// Handshakes:
//   cpu_req is a one-cycle strobe; the access is complete when cpu_rdy
//   pulses for one cycle. host_req is a level held until host_ack pulses for
//   one cycle; host_dato is valid with host_ack and is held afterwards.
//   A host access already granted always completes and always acks, even if
//   host_req drops first. Neither side has backpressure; a CPU strobe that
//   finds the one-deep pending latch full is dropped and sets cpu_ovf.
//
// state_dbg exposes the arbiter state: 0=IDLE 1=CPU_ACC 2=HOST_ACC 3=HOST_GAP.
module huc_mem_arb #(
  parameter int ADDR_W  = 22,
  parameter int MEM_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dati,
  output logic [7:0]        cpu_dato,
  output logic              cpu_rdy,
  output logic              cpu_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_dati,
  output logic [7:0]        host_dato,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dati,
  input  logic [7:0]        mem_dato,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    HOST_ACC = 2'd2,
    HOST_GAP = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_CYC - 1);

  state_t              state;
  logic [3:0]          cnt;

  // One-deep store for a CPU strobe that arrives while the port is busy.
  logic                pend_v;
  logic                pend_we;
  logic [ADDR_W-1:0]   pend_addr;
  logic [7:0]          pend_dati;

  logic [ADDR_W-1:0]   host_eff_addr;
  logic                acc_end;
  logic                cpu_dec;
  logic                grant_cpu;
  logic                grant_host;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [7:0]          sel_dati;

  assign state_dbg = state;

`ifdef HUC_MEM_ARB_HOST_AUTOINC_EN
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic              host_req_q;
  logic [ADDR_W-1:0] host_ptr;
  logic              host_rise;

  assign host_rise = host_req & ~host_req_q;
  // On the rising edge of a request the pointer is not loaded yet, so the
  // first access of a burst takes host_addr directly.
  assign host_eff_addr = host_rise ? host_addr : host_ptr;

  // Burst pointer: reload on a fresh request, step after each host access.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_req_q <= 1'b0;
      host_ptr   <= '0;
    end else begin
      host_req_q <= host_req;
      if (host_rise)
        host_ptr <= host_addr;
      else if (acc_end && (state == HOST_ACC))
        host_ptr <= host_ptr + PTR_ONE;
    end
  end
`else
  assign host_eff_addr = host_addr;
`endif

  // Grant decision. The CPU may be started from IDLE, HOST_GAP or straight
  // off the last cycle of any access; the host is only started from IDLE.
  always_comb begin
    acc_end    = ((state == CPU_ACC) || (state == HOST_ACC)) && (cnt == 4'd0);
    cpu_dec    = (state == IDLE) || (state == HOST_GAP) || acc_end;
    grant_cpu  = cpu_dec && (pend_v || cpu_req);
    grant_host = (state == IDLE) && !pend_v && !cpu_req && host_req;
    sel_we     = host_we;
    sel_addr   = host_eff_addr;
    sel_dati   = host_dati;
    if (pend_v) begin
      sel_we   = pend_we;
      sel_addr = pend_addr;
      sel_dati = pend_dati;
    end else if (cpu_req) begin
      sel_we   = cpu_we;
      sel_addr = cpu_addr;
      sel_dati = cpu_dati;
    end
  end

  // Arbiter FSM, strobe window, completion pulses and CPU pending latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend_v    <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_dati <= 8'd0;
      cpu_dato  <= 8'd0;
      cpu_rdy   <= 1'b0;
      cpu_ovf   <= 1'b0;
      host_dato <= 8'd0;
      host_ack  <= 1'b0;
      mem_addr  <= '0;
      mem_dati  <= 8'd0;
      mem_ce    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      cpu_rdy  <= 1'b0;
      host_ack <= 1'b0;

      // Completion of the running access (read data captured while oe high).
      if (acc_end) begin
        if (state == CPU_ACC) begin
          cpu_rdy <= 1'b1;
          if (mem_oe) cpu_dato <= mem_dato;
        end else begin
          host_ack <= 1'b1;
          if (mem_oe) host_dato <= mem_dato;
        end
      end

      // Pending latch: a served entry may be refilled on the same edge.
      if (grant_cpu && pend_v) begin
        pend_v <= cpu_req;
        if (cpu_req) begin
          pend_we   <= cpu_we;
          pend_addr <= cpu_addr;
          pend_dati <= cpu_dati;
        end
      end else if (cpu_req && !grant_cpu) begin
        if (!pend_v) begin
          pend_v    <= 1'b1;
          pend_we   <= cpu_we;
          pend_addr <= cpu_addr;
          pend_dati <= cpu_dati;
        end else begin
          cpu_ovf <= 1'b1;
        end
      end

      // Start a new access, or advance the current one.
      if (grant_cpu || grant_host) begin
        state    <= grant_cpu ? CPU_ACC : HOST_ACC;
        mem_addr <= sel_addr;
        mem_dati <= sel_dati;
        mem_ce   <= 1'b1;
        mem_oe   <= ~sel_we;
        mem_we   <= sel_we;
        cnt      <= CNT_INIT;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          HOST_GAP: state <= IDLE;
          CPU_ACC, HOST_ACC: begin
            if (cnt == 4'd0) begin
              mem_ce <= 1'b0;
              mem_oe <= 1'b0;
              mem_we <= 1'b0;
              state  <= (state == CPU_ACC) ? IDLE : HOST_GAP;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
